elevator_scheduler: RTL

ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

---
 rtl/elevator_scheduler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: directional call service, timed door,
// emergency stop and asynchronous reset; all outputs are registered.
module elevator_scheduler #(
  parameter int FLOORS      = 8,
  parameter int MOVE_CYCLES = 16,
  parameter int DOOR_CYCLES = 32
) (
  input  logic                      clk,
  input  logic                      a_reset,
  input  logic [FLOORS-1:0]         active_in_levels,
  input  logic [FLOORS-2:0]         active_out_up_levels,
  input  logic [FLOORS-1:1]         active_out_down_levels,
  input  logic                      door_hold,
  input  logic                      estop,
  output logic [FLOORS-1:0]         inactivate_in_levels,
  output logic [FLOORS-2:0]         inactivate_out_up_levels,
  output logic [FLOORS-1:1]         inactivate_out_down_levels,
  output logic [$clog2(FLOORS)-1:0] floor,
  output logic                      motor_up,
  output logic                      motor_down,
  output logic                      door_open,
  output logic                      dir_up,
  output logic                      buttons_block
);

  localparam int FW = $clog2(FLOORS);
  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    MOVING,
    DOOR_OPEN,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [MW-1:0]     mcnt_q, mcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [FLOORS-1:0] clr_in_q, clr_in_d;
  logic [FLOORS-2:0] clr_up_q, clr_up_d;
  logic [FLOORS-1:1] clr_dn_q, clr_dn_d;
  logic              mot_up_q, mot_up_d;
  logic              mot_dn_q, mot_dn_d;
  logic              door_q, door_d;
  logic              block_q, block_d;

  logic [FLOORS-1:0] up_v, dn_v, any_v;
  logic [FLOORS-1:0] clr_up_v, clr_dn_v, sel_v;
  logic [FW-1:0]     nxt_floor;
  logic              here_c, in_c, same_c;
  logic              above_c, below_c;
  logic              in_n, same_n, opp_n, beyond_n;
  logic              new_in, new_hall;
  logic              pul_in, pul_hall;

  function automatic logic any_above(
    input logic [FLOORS-1:0] v,
    input logic [FW-1:0]     f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (FW'(i) > f) r = r | v[i];
    return r;
  endfunction

  function automatic logic any_below(
    input logic [FLOORS-1:0] v,
    input logic [FW-1:0]     f
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++)
      if (FW'(i) < f) r = r | v[i];
    return r;
  endfunction

  // Hall vectors padded to full floor width; missing end bits are 0
  assign up_v     = {1'b0, active_out_up_levels};
  assign dn_v     = {active_out_down_levels, 1'b0};
  assign any_v    = active_in_levels | up_v | dn_v;
  assign clr_up_v = {1'b0, clr_up_q};
  assign clr_dn_v = {clr_dn_q, 1'b0};

  assign nxt_floor = dir_q ? floor_q + FW'(1)
                           : floor_q - FW'(1);

  assign here_c  = any_v[floor_q];
  assign in_c    = active_in_levels[floor_q];
  assign same_c  = dir_q ? up_v[floor_q] : dn_v[floor_q];
  assign above_c = any_above(any_v, floor_q);
  assign below_c = any_below(any_v, floor_q);

  assign in_n     = active_in_levels[nxt_floor];
  assign same_n   = dir_q ? up_v[nxt_floor] : dn_v[nxt_floor];
  assign opp_n    = dir_q ? dn_v[nxt_floor] : up_v[nxt_floor];
  assign beyond_n = dir_q ? any_above(any_v, nxt_floor)
                          : any_below(any_v, nxt_floor);

  // A call still showing its own clear pulse is not a new call
  assign new_in   = in_c & ~clr_in_q[floor_q];
  assign new_hall = dir_q ? up_v[floor_q] & ~clr_up_v[floor_q]
                          : dn_v[floor_q] & ~clr_dn_v[floor_q];

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    mcnt_d   = mcnt_q;
    dcnt_d   = dcnt_q;
    pul_in   = 1'b0;
    pul_hall = 1'b0;
    if (estop) begin
      state_d = STOP;
      mcnt_d  = '0;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (here_c) begin
            state_d  = DOOR_OPEN;
            dcnt_d   = '0;
            pul_in   = 1'b1;
            pul_hall = 1'b1;
            if (!in_c && !same_c) dir_d = ~dir_q;
          end else if (above_c && (dir_q || !below_c)) begin
            state_d = MOVING;
            dir_d   = 1'b1;
            mcnt_d  = '0;
          end else if (below_c) begin
            state_d = MOVING;
            dir_d   = 1'b0;
            mcnt_d  = '0;
          end
        end
        MOVING: begin
          if (mcnt_q == MOVE_LAST) begin
            floor_d = nxt_floor;
            mcnt_d  = '0;
            if (!(|any_v)) begin
              state_d = IDLE;
            end else if (in_n || same_n || !beyond_n) begin
              state_d  = DOOR_OPEN;
              dcnt_d   = '0;
              pul_in   = 1'b1;
              pul_hall = 1'b1;
              if (!beyond_n && opp_n) dir_d = ~dir_q;
            end
          end else begin
            mcnt_d = mcnt_q + MW'(1);
          end
        end
        DOOR_OPEN: begin
          if (door_hold || new_in || new_hall) begin
            dcnt_d   = '0;
            pul_in   = new_in;
            pul_hall = new_hall;
          end else if (dcnt_q == DOOR_LAST) begin
            state_d = IDLE;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        STOP: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < FLOORS; i++)
      sel_v[i] = (FW'(i) == floor_d);
  end

  always_comb begin
    clr_in_d = pul_in ? sel_v : '0;
    clr_up_d = (pul_hall && dir_d) ? sel_v[FLOORS-2:0] : '0;
    clr_dn_d = (pul_hall && !dir_d) ? sel_v[FLOORS-1:1] : '0;
    mot_up_d = (state_d == MOVING) && dir_d;
    mot_dn_d = (state_d == MOVING) && !dir_d;
    door_d   = (state_d == DOOR_OPEN);
    block_d  = (state_d == STOP);
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state_q  <= IDLE;
      floor_q  <= '0;
      dir_q    <= 1'b1;
      mcnt_q   <= '0;
      dcnt_q   <= '0;
      clr_in_q <= '0;
      clr_up_q <= '0;
      clr_dn_q <= '0;
      mot_up_q <= 1'b0;
      mot_dn_q <= 1'b0;
      door_q   <= 1'b0;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      mcnt_q   <= mcnt_d;
      dcnt_q   <= dcnt_d;
      clr_in_q <= clr_in_d;
      clr_up_q <= clr_up_d;
      clr_dn_q <= clr_dn_d;
      mot_up_q <= mot_up_d;
      mot_dn_q <= mot_dn_d;
      door_q   <= door_d;
      block_q  <= block_d;
    end
  end

  assign inactivate_in_levels       = clr_in_q;
  assign inactivate_out_up_levels   = clr_up_q;
  assign inactivate_out_down_levels = clr_dn_q;
  assign floor         = floor_q;
  assign motor_up      = mot_up_q;
  assign motor_down    = mot_dn_q;
  assign door_open     = door_q;
  assign dir_up        = dir_q;
  assign buttons_block = block_q;

endmodule
